// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit types and defaults for the CPU core.
// Holds the architectural control-state record and the default vector layout.
package lib_cpu;
  localparam int DEF_PC_W       = 11;
  localparam int DEF_VEC_BASE   = 16;
  localparam int DEF_VEC_STRIDE = 4;

  typedef struct packed {
    logic [DEF_PC_W-1:0] pc;
    logic                intr_en;
    logic [DEF_PC_W-1:0] intr_pc;
  } CTRL_STATE;

  // Index width that stays legal for a single channel.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cpu_ctrl_if.sv
// Execute-stage / writer-side bundle of the multi-cycle control unit.
interface cpu_ctrl_if #(
  parameter int PC_W   = 11,
  parameter int NPHASE = 5,
  parameter int NIRQ   = 4
);
  logic              stall;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_iret;
  logic              ex_ien_we;
  logic              ex_ien_val;
  logic [NIRQ-1:0]   irq;
  logic [NPHASE-1:0] phase;
  logic              commit;
  logic [PC_W-1:0]   pc;
  logic              intr_en;
  logic [PC_W-1:0]   intr_pc;
  logic [NIRQ-1:0]   irq_pending;
  logic [NIRQ-1:0]   irq_ack;
  logic [31:0]       instret;

  modport master (
    output stall, ex_pc, ex_iret, ex_ien_we, ex_ien_val, irq,
    input  phase, commit, pc, intr_en, intr_pc, irq_pending, irq_ack, instret
  );
  modport slave (
    input  stall, ex_pc, ex_iret, ex_ien_we, ex_ien_val, irq,
    output phase, commit, pc, intr_en, intr_pc, irq_pending, irq_ack, instret
  );
endinterface

// File: rtl/cpu_ctrl_irq_prio_latch.sv
// Edge-latched pending interrupt register with a lowest-index-wins encoder.
// A fresh edge on a channel beats a same-cycle clear of that channel.
module irq_prio_latch
  import lib_cpu::*;
#(
  parameter  int NIRQ  = 4,
  localparam int IDX_W = idx_w(NIRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NIRQ-1:0]  irq,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  output logic [NIRQ-1:0]  pending,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  logic [NIRQ-1:0] irq_prev;
  logic [NIRQ-1:0] clr_vec;

  assign clr_vec = clr_en ? (NIRQ'(1) << clr_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev <= '0;
      pending  <= '0;
    end else begin
      irq_prev <= irq;
      pending  <= (irq & ~irq_prev) | (pending & ~clr_vec);
    end
  end

  always_comb begin
    valid = |pending;
    idx   = '0;
    for (int i = NIRQ - 1; i >= 0; i--)
      if (pending[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: one-hot phase ring, PC, interrupt enable/return
// state and a vectored fixed-priority interrupt controller.
module cpu_ctrl
  import lib_cpu::*;
#(
  parameter int PC_W       = DEF_PC_W,
  parameter int NPHASE     = 5,
  parameter int NIRQ       = 4,
  parameter int RESET_PC   = 0,
  parameter int VEC_BASE   = DEF_VEC_BASE,
  parameter int VEC_STRIDE = DEF_VEC_STRIDE
) (
  input logic      clk,
  input logic      reset,
  cpu_ctrl_if.slave bus
);
  localparam int IDX_W = idx_w(NIRQ);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            intr_en;
    logic [PC_W-1:0] intr_pc;
  } state_t;

  state_t            st;
  logic [NPHASE-1:0] phase, phase_nxt;
  logic [NIRQ-1:0]   irq_ack, ack_nxt, pending;
  logic [31:0]       instret;
  logic              commit, take, irq_valid;
  logic [IDX_W-1:0]  irq_idx;
  logic [PC_W-1:0]   vec_pc;

  generate
    if (NPHASE == 1) begin : g_ph1
      assign phase_nxt = 1'b1;
    end else begin : g_phn
      assign phase_nxt = (phase[NPHASE-1] & bus.stall) ? phase
                                                       : {phase[NPHASE-2:0], phase[NPHASE-1]};
    end
  endgenerate

  assign commit  = phase[NPHASE-1] & ~bus.stall & ~reset;
  // Enable is the pre-commit value; a return commit never takes.
  assign take    = commit & st.intr_en & irq_valid & ~bus.ex_iret;
  assign vec_pc  = PC_W'(VEC_BASE) + PC_W'(irq_idx) * PC_W'(VEC_STRIDE);
  assign ack_nxt = take ? (NIRQ'(1) << irq_idx) : '0;

  irq_prio_latch #(.NIRQ(NIRQ)) u_irq (
    .clk     (clk),
    .reset   (reset),
    .irq     (bus.irq),
    .clr_en  (take),
    .clr_idx (irq_idx),
    .pending (pending),
    .valid   (irq_valid),
    .idx     (irq_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= NPHASE'(1);
      st      <= '{pc: PC_W'(RESET_PC), intr_en: 1'b0, intr_pc: '0};
      irq_ack <= '0;
      instret <= '0;
    end else begin
      phase   <= phase_nxt;
      irq_ack <= ack_nxt;
      if (commit) begin
        instret <= instret + 32'd1;
        if (take) begin
          st.intr_pc <= bus.ex_pc;
          st.pc      <= vec_pc;
          st.intr_en <= 1'b0;
        end else if (bus.ex_iret) begin
          st.pc      <= st.intr_pc;
          st.intr_en <= 1'b1;
        end else begin
          st.pc <= bus.ex_pc;
          if (bus.ex_ien_we) st.intr_en <= bus.ex_ien_val;
        end
      end
    end
  end

  assign bus.phase       = phase;
  assign bus.commit      = commit;
  assign bus.pc          = st.pc;
  assign bus.intr_en     = st.intr_en;
  assign bus.intr_pc     = st.intr_pc;
  assign bus.irq_pending = pending;
  assign bus.irq_ack     = irq_ack;
  assign bus.instret     = instret;
endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: vector table for sequencing/stall, hand-written
// sequences for interrupt take, return, edge-vs-clear and mid-instruction reset.
module tb_cpu_ctrl;
  import lib_cpu::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_ctrl_if #(.PC_W(11), .NPHASE(5), .NIRQ(4)) bus ();

  cpu_ctrl #(.PC_W(11), .NPHASE(5), .NIRQ(4), .RESET_PC(0),
             .VEC_BASE(16), .VEC_STRIDE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        stall;
    logic [10:0] ex_pc;
    logic [4:0]  e_phase;
    logic        e_commit;
    CTRL_STATE   e_st;
    logic [31:0] e_instret;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [10:0] epc, input logic ir,
                       input logic we, input logic val, input logic [3:0] q);
    bus.stall = s; bus.ex_pc = epc; bus.ex_iret = ir;
    bus.ex_ien_we = we; bus.ex_ien_val = val; bus.irq = q;
  endtask

  function automatic vec_t v(input logic s, input logic [10:0] epc, input logic [4:0] ph,
                             input logic cm, input logic [10:0] xpc, input logic [31:0] ir);
    vec_t r;
    r.stall = s; r.ex_pc = epc; r.e_phase = ph; r.e_commit = cm;
    r.e_st = '{pc: xpc, intr_en: 1'b0, intr_pc: 11'd0};
    r.e_instret = ir;
    return r;
  endfunction

  // Runs from the current negedge until one commit; returns at the negedge after it.
  task automatic finish_instr(input logic [10:0] epc, input logic ir, input logic we,
                              input logic val, input logic [3:0] q);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      drive(1'b0, epc, ir, we, val, q);
      #1;
      if (bus.commit) done = 1;
      @(negedge clk);
    end
    chk("commit_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_phase"},   32'(bus.phase), 32'd1);
    chk({tag, "_commit"},  32'(bus.commit), 32'd0);
    chk({tag, "_pc"},      32'(bus.pc), 32'd0);
    chk({tag, "_ien"},     32'(bus.intr_en), 32'd0);
    chk({tag, "_ipc"},     32'(bus.intr_pc), 32'd0);
    chk({tag, "_pend"},    32'(bus.irq_pending), 32'd0);
    chk({tag, "_ack"},     32'(bus.irq_ack), 32'd0);
    chk({tag, "_instret"}, bus.instret, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_state("rst");
    reset = 1'b0;

    // Three free-running instructions with ex_pc = pc+1.
    for (int n = 0; n < 3; n++)
      for (int j = 0; j < 5; j++)
        tbl.push_back(v(1'b0, 11'(n + 1), 5'(1 << j), j == 4, 11'(n), 32'(n)));
    tbl.push_back(v(1'b0, 11'd4, 5'd1,  1'b0, 11'd3, 32'd3));
    tbl.push_back(v(1'b0, 11'd4, 5'd2,  1'b0, 11'd3, 32'd3));
    tbl.push_back(v(1'b0, 11'd4, 5'd4,  1'b0, 11'd3, 32'd3));
    tbl.push_back(v(1'b0, 11'd4, 5'd8,  1'b0, 11'd3, 32'd3));
    tbl.push_back(v(1'b1, 11'd4, 5'd16, 1'b0, 11'd3, 32'd3));
    tbl.push_back(v(1'b1, 11'd4, 5'd16, 1'b0, 11'd3, 32'd3));
    tbl.push_back(v(1'b1, 11'd4, 5'd16, 1'b0, 11'd3, 32'd3));
    tbl.push_back(v(1'b0, 11'd4, 5'd16, 1'b1, 11'd3, 32'd3));
    tbl.push_back(v(1'b0, 11'd5, 5'd1,  1'b0, 11'd4, 32'd4));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].ex_pc, 1'b0, 1'b0, 1'b0, 4'b0000);
      #1;
      chk($sformatf("v%0d_phase", i),   32'(bus.phase),   32'(tbl[i].e_phase));
      chk($sformatf("v%0d_commit", i),  32'(bus.commit),  32'(tbl[i].e_commit));
      chk($sformatf("v%0d_pc", i),      32'(bus.pc),      32'(tbl[i].e_st.pc));
      chk($sformatf("v%0d_ien", i),     32'(bus.intr_en), 32'(tbl[i].e_st.intr_en));
      chk($sformatf("v%0d_ipc", i),     32'(bus.intr_pc), 32'(tbl[i].e_st.intr_pc));
      chk($sformatf("v%0d_instret", i), bus.instret,      tbl[i].e_instret);
      @(negedge clk);
    end

    // Enable interrupts.
    finish_instr(11'd5, 1'b0, 1'b1, 1'b1, 4'b0000);
    chk("ien_pc", 32'(bus.pc), 32'd5);
    chk("ien_set", 32'(bus.intr_en), 32'd1);
    chk("ien_instret", bus.instret, 32'd5);

    // Two channels rise; channel 1 wins.
    finish_instr(11'd7, 1'b0, 1'b0, 1'b0, 4'b0110);
    chk("take1_pc", 32'(bus.pc), 32'd20);
    chk("take1_ipc", 32'(bus.intr_pc), 32'd7);
    chk("take1_ien", 32'(bus.intr_en), 32'd0);
    chk("take1_pend", 32'(bus.irq_pending), 32'b0100);
    chk("take1_ack", 32'(bus.irq_ack), 32'b0010);
    chk("take1_instret", bus.instret, 32'd6);
    @(negedge clk);
    chk("take1_ack_drop", 32'(bus.irq_ack), 32'd0);

    // Return with channel 2 still pending: no take on this commit.
    finish_instr(11'd21, 1'b1, 1'b0, 1'b0, 4'b0110);
    chk("iret_pc", 32'(bus.pc), 32'd7);
    chk("iret_ien", 32'(bus.intr_en), 32'd1);
    chk("iret_pend", 32'(bus.irq_pending), 32'b0100);
    chk("iret_ack", 32'(bus.irq_ack), 32'd0);

    finish_instr(11'd8, 1'b0, 1'b0, 1'b0, 4'b0110);
    chk("take2_pc", 32'(bus.pc), 32'd24);
    chk("take2_ipc", 32'(bus.intr_pc), 32'd8);
    chk("take2_ack", 32'(bus.irq_ack), 32'b0100);
    chk("take2_pend", 32'(bus.irq_pending), 32'd0);

    // Return while channel 0 gets latched.
    finish_instr(11'd25, 1'b1, 1'b0, 1'b0, 4'b0001);
    chk("iret2_pc", 32'(bus.pc), 32'd8);
    chk("iret2_pend", 32'(bus.irq_pending), 32'b0001);
    chk("iret2_ack", 32'(bus.irq_ack), 32'd0);

    // Channel 0 re-edges in the very cycle its take clears it.
    begin
      bit done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
        drive(1'b0, 11'd9, 1'b0, 1'b0, 1'b0, bus.phase[4] ? 4'b0001 : 4'b0000);
        #1;
        if (bus.commit) done = 1;
        @(negedge clk);
      end
      chk("edge_clr_commit", {31'd0, done}, 32'd1);
    end
    chk("edge_clr_pc", 32'(bus.pc), 32'd16);
    chk("edge_clr_ipc", 32'(bus.intr_pc), 32'd9);
    chk("edge_clr_ack", 32'(bus.irq_ack), 32'b0001);
    chk("edge_clr_pend", 32'(bus.irq_pending), 32'b0001);

    // Reset in phase 4 with a pending interrupt and irq held high.
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_phase", 32'(bus.phase), 32'd4);
    reset = 1'b1;
    @(negedge clk); #1;
    chk_reset_state("midrst");
    @(negedge clk);
    chk("rst_level_pend", 32'(bus.irq_pending), 32'd0);
    reset = 1'b0;
    drive(1'b0, 11'd1, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    chk("post_rst_phase", 32'(bus.phase), 32'd2);
    chk("post_rst_pend", 32'(bus.irq_pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Parametrised multi-cycle control unit for the next-generation CPU core.
- Owns four things:
  - the one-hot phase ring, generalised to NPHASE phases, with a stall hold in the last phase;
  - the program counter;
  - the interrupt-enable / interrupt-return state;
  - an NIRQ-channel, edge-latched, fixed-priority vectored interrupt controller.
- Sits between the ALU/execute stage (which supplies next-PC and control flags) and the ROM/register-file/memory writers (which consume `commit` as their write enable).

Parameters:
- PC_W, 11: program counter width; also the ROM address width.
- NPHASE, 5: cycles per instruction; must be ≥1.
- NIRQ, 4: number of interrupt channels; must be ≥1.
- RESET_PC, 0: PC value loaded on reset.
- VEC_BASE, 16: PC of the vector for channel 0.
- VEC_STRIDE, 4: PC distance between consecutive channel vectors.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- stall  in  1  holds the last phase; commit is blocked while high.
- ex_pc  in  PC_W  next-sequential/branch PC from execute.
- ex_iret  in  1  current instruction is an interrupt return.
- ex_ien_we  in  1  current instruction writes intr_en.
- ex_ien_val  in  1  value written to intr_en.
- irq  in  NIRQ  level interrupt request lines.
- phase  out  NPHASE  one-hot phase ring.
- commit  out  1  architectural update strobe (combinational).
- pc  out  PC_W  current PC; drives rom_addr.
- intr_en  out  1  global interrupt enable.
- intr_pc  out  PC_W  saved return PC.
- irq_pending  out  NIRQ  latched pending requests.
- irq_ack  out  NIRQ  one-cycle acknowledge pulse per channel.
- instret  out  32  committed-instruction counter.

Behaviour:
- Reset: clock clk; reset is synchronous, active-high.
  - phase = 1 (bit0), pc = RESET_PC, intr_en = 0, intr_pc = 0.
  - irq_pending = 0, irq edge history = 0, irq_ack = 0, instret = 0.
  - Reset mid-instruction discards all in-flight state.
- Phase ring:
  - Rotates left one bit per cycle.
  - When phase[NPHASE-1] = 1 and stall = 1, the ring holds.
  - stall is ignored in all other phases.
  - If NPHASE = 1, phase is constantly 1.
- commit = phase[NPHASE-1] & ~stall & ~reset.
  - All state below changes only on a commit cycle, except irq edge capture and irq_ack.
- IRQ capture, every cycle:
  - irq_prev <= irq.
  - Channel i is set pending on a rising edge: irq[i] & ~irq_prev[i].
  - An edge arriving in the same cycle as a clear of that channel wins: the channel stays pending.
- Interrupt take, at commit:
  - Condition: intr_en = 1 (pre-commit value) & |irq_pending & ~ex_iret.
  - k = lowest set index of irq_pending.
  - Updates: intr_pc <= ex_pc; pc <= VEC_BASE + k*VEC_STRIDE (truncated to PC_W); intr_en <= 0; irq_pending[k] <= 0.
  - irq_ack <= one-hot(k). irq_ack is registered, so it is high in the cycle after commit, for exactly one cycle.
  - A take overrides ex_ien_we.
- Return, at commit, no take:
  - If ex_iret: pc <= intr_pc; intr_en <= 1.
  - Pending interrupts are not taken on the same commit as a return; the earliest take is the next commit.
- Otherwise, at commit:
  - pc <= ex_pc.
  - If ex_ien_we: intr_en <= ex_ien_val.
  - An enable written here takes effect from the next commit.
- instret:
  - Increments by 1 on every commit, including commits where an interrupt is taken.
  - Wraps from 2^32-1 to 0.
- PC arithmetic: all PC arithmetic is mod 2^PC_W.

Decomposition:
- Package `lib_cpu` gains:
  - a `CTRL_STATE` struct (pc, intr_en, intr_pc);
  - localparams for the default vector base and stride.
- One sub-module: `irq_prio_latch`. It implements edge detect, the pending register, and the lowest-index priority encoder, outputting `valid` and `idx`, with a `clr_en`/`clr_idx` clear port.

Test Plan:
- Reset, then free-run with stall = 0, ex_pc = pc+1:
  - phase sequence is 1, 2, 4, 8, 16, 1;
  - commit fires every 5th cycle;
  - pc goes 0, 1, 2;
  - instret = 3 after 15 cycles.
- Hold stall = 1 for 3 cycles while phase = 16:
  - phase stays at 16 and commit = 0 for those cycles;
  - commit fires on the cycle stall drops, and the pc update is delayed by 3 cycles.
- Set intr_en via ex_ien_we = 1, ex_ien_val = 1, then raise irq = 4'b0110 with ex_pc = 7:
  - at the next commit, pc = 16 + 1*4 = 20 and intr_pc = 7;
  - intr_en = 0, irq_pending = 4'b0100;
  - irq_ack = 4'b0010 for exactly one cycle.
- Issue ex_iret with channel 2 still pending:
  - pc = 7 and intr_en = 1;
  - no take on that commit;
  - the next commit jumps to pc = 24, irq_ack = 4'b0100.
- Pulse irq[0] 0→1 in the same cycle that a take clears channel 0:
  - irq_pending[0] remains 1.
- Assert reset during phase 4 with a pending interrupt:
  - all outputs return to their reset values the next cycle;
  - irq_ack = 0;
  - a level-high irq without a new edge is not re-latched.
